// File: rtl/serial_addsub_if.sv
// Handshake and operand bus for the bit-serial adder/subtractor.
//   start, sub, a, b       : request side (driven by the master)
//   ready, busy, done      : handshake status (driven by the slave)
//   result, cout           : held result and carry/borrow out (driven by the slave)
interface serial_addsub_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;

    modport master (
        output start, sub, a, b,
        input  ready, busy, done, result, cout
    );

    modport slave (
        input  start, sub, a, b,
        output ready, busy, done, result, cout
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial unsigned adder/subtractor: one full-adder/subtractor stage plus a
// carry/borrow flip-flop, iterated LSB-first over WIDTH cycles.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : serial_addsub_if slave (start/sub/a/b in; ready/busy/done/result/cout out)
//
// state | meaning
// IDLE  | waiting for start, ready=1
// RUN   | processing one bit per edge, busy=1
// DONE  | result/cout valid, done pulse, ready=1 (back-to-back start accepted)
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    serial_addsub_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 bits already produced; the final bit joins them at the
    // RUN->DONE edge so the result port never shows partial values.
    logic [WIDTH-2:0] acc;
    logic [CW-1:0]    cnt;
    logic             cb;
    logic             sub_q;

    logic             ai;
    logic             bi;
    logic             s_bit;
    logic             cb_next;
    logic             last;

    always_comb begin
        ai      = a_sr[0];
        bi      = b_sr[0];
        s_bit   = ai ^ bi ^ cb;
        cb_next = sub_q ? ((~ai & bi) | (cb & ~(ai ^ bi)))
                        : ((ai & bi) | (cb & (ai ^ bi)));
        last    = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            acc        <= '0;
            cnt        <= '0;
            cb         <= 1'b0;
            sub_q      <= 1'b0;
            bus.ready  <= 1'b1;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
            bus.cout   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_sr      <= bus.a;
                        b_sr      <= bus.b;
                        sub_q     <= bus.sub;
                        cnt       <= '0;
                        cb        <= 1'b0;
                        bus.ready <= 1'b0;
                        bus.busy  <= 1'b1;
                        state     <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    acc  <= (WIDTH-1)'({s_bit, acc} >> 1);
                    cb   <= cb_next;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        bus.result <= {s_bit, acc};
                        bus.cout   <= cb_next;
                        bus.done   <= 1'b1;
                        bus.busy   <= 1'b0;
                        bus.ready  <= 1'b1;
                        state      <= DONE;
                    end
                end
                default: begin
                    bus.ready <= 1'b1;
                    bus.busy  <= 1'b0;
                    bus.done  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
